// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// It uses shift-add multiply and restoring divide on operand magnitudes, then applies sign correction in FIX.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_next;
    logic               is_div, neg_res, neg_rem, div_zero;
    logic [W-1:0]       opnd;
    logic [2*W-1:0]     acc, acc_step;
    logic [CW-1:0]      count;

    logic               op_signed;
    logic [W-1:0]       a_abs, b_abs;
    logic [W:0]         mul_sum, div_shift;
    logic [W+1:0]       div_diff;
    logic [2*W-1:0]     prod_fix;
    logic [W-1:0]       q_fix, r_fix;

    // Operand magnitudes: two's-complement absolute value for signed ops
    always_comb begin
        op_signed = ~op[0];
        a_abs     = (op_signed && rs_data[W-1]) ? W'(-rs_data) : rs_data;
        b_abs     = (op_signed && rt_data[W-1]) ? W'(-rt_data) : rt_data;
    end

    // One iteration: multiplier / dividend bits are consumed from acc's low half
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : (W+1)'(0));
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        if (is_div) begin
            acc_step = div_diff[W+1] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                                     : {div_diff[W-1:0],  acc[W-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[W-1:1]};
        end
    end

    // Sign correction applied on the way into HI/LO
    always_comb begin
        prod_fix = neg_res ? (2*W)'(-acc) : acc;
        q_fix    = div_zero ? '1 : (neg_res ? W'(-acc[W-1:0]) : acc[W-1:0]);
        r_fix    = neg_rem ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == CW'(W - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            opnd     <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state == FIX);
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        is_div   <= op[1];
                        neg_res  <= op_signed && (rs_data[W-1] ^ rt_data[W-1]);
                        neg_rem  <= op_signed && rs_data[W-1];
                        div_zero <= op[1] && (rt_data == '0);
                        acc      <= {{W{1'b0}}, (op[1] ? a_abs : b_abs)};
                        opnd     <= op[1] ? b_abs : a_abs;
                        count    <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= prod_fix[2*W-1:W];
                        lo <= prod_fix[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
